io_port_unit: RTL and testbench
===============================

Name: io_port_unit

Overview:
- Responder side of the processor's IN/OUT port instructions.
- Buffers bytes written by OUT instructions in a TX FIFO. They drain to an external device over a valid/ready link.
- Collects bytes from an external device in an RX FIFO. IN instructions consume these bytes.
- Stalls the pipeline when an IN finds the RX FIFO empty or an OUT finds the TX FIFO full. A watchdog aborts stalls that last too long.

Parameters:
DATA_W, 8, port byte width (matches register width)
DEPTH, 4, entries per FIFO; must be a power of 2, at least 2
STALL_LIMIT, 16, consecutive stall cycles before abort; range 1..255

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_req  in  1  pipeline is executing an IN this cycle
out_req  in  1  pipeline is executing an OUT this cycle; never asserted together with in_req
out_data  in  DATA_W  byte to send for OUT
cpu_in_data  out  DATA_W  byte returned to the pipeline for IN
cpu_stall  out  1  freeze the pipeline; the request is re-presented next cycle
tx_valid  out  1  TX FIFO has data for the device
tx_data  out  DATA_W  TX FIFO head
tx_ready  in  1  device accepts tx_data
rx_valid  in  1  device offers rx_data
rx_data  in  DATA_W  incoming byte
rx_ready  out  1  RX FIFO can accept a byte
tx_count  out  clog2(DEPTH)+1  TX occupancy
rx_count  out  clog2(DEPTH)+1  RX occupancy
io_err  out  1  sticky watchdog-abort flag
err_clr  in  1  clears io_err

Behaviour:

Reset (rst low, asynchronous):
- Pointers, counts, storage, watchdog counter and io_err all go to 0. FSM goes to IDLE.
- Resulting outputs: tx_valid=0, tx_data=0, rx_ready=1, cpu_stall=0, cpu_in_data=0.
- Reset mid-operation discards all buffered bytes.

FIFOs:
- Circular buffers with DEPTH entries. Pointers wrap modulo DEPTH. Counts run 0..DEPTH.
- TX push: out_req && !cpu_stall && !abort.
- TX pop: tx_valid && tx_ready.
- RX push: rx_valid && rx_ready.
- RX pop: in_req && !cpu_stall, with no abort.
- tx_valid = (tx_count != 0). rx_ready = (rx_count != DEPTH). Both are combinational from the counts.
- tx_data = mem[rd_ptr] and cpu_in_data = RX head, both combinational. On abort, cpu_in_data = 0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- No bypass paths:
  - out_req on a full TX FIFO stalls even if tx_ready pops that same cycle.
  - in_req on an empty RX FIFO stalls even if rx_valid pushes that same cycle.
- Empty/full guards: no push when full, no pop when empty. Counts never overflow or underflow.

Stall condition:
- raw_stall = (in_req && rx_count==0) || (out_req && tx_count==DEPTH).
- cpu_stall = raw_stall && state != ABORT. It is combinational, so it affects the same cycle.

Watchdog FSM:
- IDLE: raw_stall → WAIT, stall_cnt=1.
- WAIT:
  - !raw_stall → IDLE, stall_cnt=0.
  - stall_cnt==STALL_LIMIT → ABORT.
  - Otherwise stall_cnt increments.
- ABORT (exactly one cycle):
  - cpu_stall=0, so the request completes.
  - IN returns 0 and pops nothing. OUT is dropped and pushes nothing.
  - io_err is set to 1. Next state is IDLE, stall_cnt=0.
- Net effect: a stalled request sees STALL_LIMIT+1 stall cycles, then completes in the ABORT cycle.

io_err:
- err_clr clears io_err on the next edge. Setting wins over clearing in the same cycle.
- The FIFOs keep operating while io_err=1.

Test Plan:
- OUT 0xA5, 0x3C with tx_ready=1 → tx_valid rises the cycle after each push; device sees 0xA5 then 0x3C; tx_count returns to 0; cpu_stall never asserts.
- tx_ready=0, four OUTs 0x01..0x04, then a fifth OUT 0x05 → tx_count=4, cpu_stall=1 on the fifth. Raise tx_ready one cycle: stall still 1 that cycle, OUT accepted next cycle, drain order 01..05.
- Device pushes 0x11, 0x22, 0x33, 0x44, 0x55 with no IN → rx_ready=0 after the fourth; 0x55 is held by the device. IN×4 returns 11, 22, 33, 44, then 0x55 is accepted.
- IN with RX empty, STALL_LIMIT=16, no device data → cpu_stall high for 17 cycles, then one cycle with cpu_stall=0, cpu_in_data=0x00, io_err=1. After err_clr, io_err=0.
- IN on empty RX, device pushes 0x7E at cycle 3 of the stall → cpu_stall drops the cycle after the push, cpu_in_data=0x7E, io_err=0, watchdog back in IDLE.
- Pull rst low mid-drain with tx_count=3 → tx_valid=0, counts=0, rx_ready=1 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/io_port_if.sv
// io_port_if: CPU-side IN/OUT request signals and device-side TX/RX valid/ready links of the port unit.
interface io_port_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              in_req;
    logic              out_req;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_stall;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic [CW-1:0]     tx_count;
    logic [CW-1:0]     rx_count;
    logic              io_err;
    logic              err_clr;
    modport slave (
        input  in_req, out_req, out_data, tx_ready, rx_valid, rx_data, err_clr,
        output cpu_in_data, cpu_stall, tx_valid, tx_data, rx_ready, tx_count, rx_count, io_err
    );
    modport master (
        output in_req, out_req, out_data, tx_ready, rx_valid, rx_data, err_clr,
        input  cpu_in_data, cpu_stall, tx_valid, tx_data, rx_ready, tx_count, rx_count, io_err
    );
endinterface

// File: rtl/io_port_unit.sv
// io_port_unit: IN/OUT port responder with TX/RX FIFOs, pipeline stall and a stall watchdog.
module io_port_unit #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 16
) (
    input logic     clk,
    input logic     rst,
    io_port_if.slave io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] ABORT = 2'd2;

    logic [1:0]        state;
    logic [7:0]        stall_cnt;
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [AW-1:0]     tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic              raw_stall, abort, stall, tx_push, tx_pop, rx_push, rx_pop;

    // No bypass: an empty RX or full TX stalls regardless of same-cycle device traffic.
    always_comb begin
        abort     = state == ABORT;
        raw_stall = (io.in_req && rx_cnt == '0) || (io.out_req && tx_cnt == CW'(DEPTH));
        stall     = raw_stall && !abort;
        tx_push   = io.out_req && !stall && !abort;
        tx_pop    = tx_cnt != '0 && io.tx_ready;
        rx_push   = io.rx_valid && rx_cnt != CW'(DEPTH);
        rx_pop    = io.in_req && !stall && !abort;
    end

    assign io.cpu_stall   = stall;
    assign io.tx_valid    = tx_cnt != '0;
    assign io.tx_data     = tx_mem[tx_rd];
    assign io.rx_ready    = rx_cnt != CW'(DEPTH);
    assign io.cpu_in_data = abort ? '0 : rx_mem[rx_rd];
    assign io.tx_count    = tx_cnt;
    assign io.rx_count    = rx_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem[i] <= '0;
                rx_mem[i] <= '0;
            end
            tx_wr  <= '0;
            tx_rd  <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= io.out_data;
                tx_wr         <= tx_wr + 1'b1;
            end
            if (tx_pop) tx_rd <= tx_rd + 1'b1;
            if (rx_push) begin
                rx_mem[rx_wr] <= io.rx_data;
                rx_wr         <= rx_wr + 1'b1;
            end
            if (rx_pop) rx_rd <= rx_rd + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // Watchdog: STALL_LIMIT+1 stalled cycles, then a single ABORT cycle lets the request complete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stall_cnt <= '0;
            io.io_err <= 1'b0;
        end else begin
            if (abort || (state == WAIT && !raw_stall)) begin
                state     <= IDLE;
                stall_cnt <= '0;
            end else if (state == IDLE) begin
                if (raw_stall) begin
                    state     <= WAIT;
                    stall_cnt <= 8'd1;
                end
            end else if (stall_cnt == 8'(STALL_LIMIT)) begin
                state <= ABORT;
            end else begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            io.io_err <= abort ? 1'b1 : io.err_clr ? 1'b0 : io.io_err;
        end
    end
endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: table-driven directed vectors, watchdog/reset sequences and randomized traffic vs a queue model.
module tb_io_port_unit;
    localparam int DW = 8, DEPTH = 4, LIMIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    io_port_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
    io_port_unit #(.DATA_W(DW), .DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .io(bus));

    int n_chk = 0, n_fail = 0;
    logic [7:0] txq[$], rxq[$];
    int run = 0;
    bit err = 0;
    logic s_stall, s_err, s_tv, s_rr;
    logic [7:0] s_cid, s_td;
    int s_tc, s_rc;

    typedef struct {
        bit in_r, out_r; logic [7:0] od; bit trdy, rv; logic [7:0] rd;
        bit st, tv; int td; bit rr; int cid; int tc, rc;
    } vec_t;
    vec_t tbl[$];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: sample at negedge, compare against the model, advance the model at posedge.
    task automatic step();
        bit raw, ab, st, tpush, tpop, rpush, rpop, clr;
        logic [7:0] od, rd;
        @(negedge clk);
        s_stall = bus.cpu_stall; s_err = bus.io_err; s_tv = bus.tx_valid; s_rr = bus.rx_ready;
        s_cid = bus.cpu_in_data; s_td = bus.tx_data; s_tc = int'(bus.tx_count); s_rc = int'(bus.rx_count);
        raw = (bus.in_req && rxq.size() == 0) || (bus.out_req && txq.size() == DEPTH);
        ab  = run == LIMIT + 1;
        st  = raw && !ab;
        check("m_stall", s_stall, st);
        check("m_tx_valid", s_tv, txq.size() != 0);
        if (txq.size() != 0) check("m_tx_data", s_td, txq[0]);
        check("m_rx_ready", s_rr, rxq.size() != DEPTH);
        check("m_tx_count", s_tc, txq.size());
        check("m_rx_count", s_rc, rxq.size());
        check("m_io_err", s_err, err);
        if (ab) check("m_abort_data", s_cid, 0);
        else if (rxq.size() != 0) check("m_in_data", s_cid, rxq[0]);
        tpush = bus.out_req && !st && !ab;
        tpop  = txq.size() != 0 && bus.tx_ready;
        rpush = bus.rx_valid && rxq.size() != DEPTH;
        rpop  = bus.in_req && !st && !ab;
        clr = bus.err_clr; od = bus.out_data; rd = bus.rx_data;
        @(posedge clk);
        if (tpop) void'(txq.pop_front());
        if (tpush) txq.push_back(od);
        if (rpop) void'(rxq.pop_front());
        if (rpush) rxq.push_back(rd);
        err = ab ? 1'b1 : clr ? 1'b0 : err;
        run = ab ? 0 : raw ? run + 1 : 0;
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_req = 0; bus.out_req = 0; bus.out_data = 0; bus.tx_ready = 0;
        bus.rx_valid = 0; bus.rx_data = 0; bus.err_clr = 0;
    endtask

    initial begin
        int stalls;
        //                in out od    trdy rv rd     st tv td     rr cid    tc rc
        tbl.push_back('{0, 1, 8'hA5, 1, 0, 8'h00, 0, 0, -1,    1, -1,    0, 0});
        tbl.push_back('{0, 1, 8'h3C, 1, 0, 8'h00, 0, 1, 'hA5,  1, -1,    1, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 'h3C,  1, -1,    1, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, -1,    1, -1,    0, 0});
        tbl.push_back('{0, 1, 8'h01, 0, 0, 8'h00, 0, 0, -1,    1, -1,    0, 0});
        tbl.push_back('{0, 1, 8'h02, 0, 0, 8'h00, 0, 1, 'h01,  1, -1,    1, 0});
        tbl.push_back('{0, 1, 8'h03, 0, 0, 8'h00, 0, 1, 'h01,  1, -1,    2, 0});
        tbl.push_back('{0, 1, 8'h04, 0, 0, 8'h00, 0, 1, 'h01,  1, -1,    3, 0});
        tbl.push_back('{0, 1, 8'h05, 0, 0, 8'h00, 1, 1, 'h01,  1, -1,    4, 0});
        tbl.push_back('{0, 1, 8'h05, 1, 0, 8'h00, 1, 1, 'h01,  1, -1,    4, 0});
        tbl.push_back('{0, 1, 8'h05, 0, 0, 8'h00, 0, 1, 'h02,  1, -1,    3, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 'h02,  1, -1,    4, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 'h03,  1, -1,    3, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 'h04,  1, -1,    2, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 'h05,  1, -1,    1, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, -1,    1, -1,    0, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h11, 0, 0, -1,    1, -1,    0, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h22, 0, 0, -1,    1, 'h11,  0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h33, 0, 0, -1,    1, 'h11,  0, 2});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h44, 0, 0, -1,    1, 'h11,  0, 3});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 8'h55, 0, 0, -1,    0, 'h11,  0, 4});
        tbl.push_back('{1, 0, 8'h00, 0, 1, 8'h55, 0, 0, -1,    0, 'h11,  0, 4});
        tbl.push_back('{1, 0, 8'h00, 0, 1, 8'h55, 0, 0, -1,    1, 'h22,  0, 3});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, -1,    1, 'h33,  0, 3});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, -1,    1, 'h44,  0, 2});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, -1,    1, 'h55,  0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, -1,    1, -1,    0, 0});

        idle_inputs();
        #1;
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_rx_ready", bus.rx_ready, 1);
        check("rst_stall", bus.cpu_stall, 0);
        check("rst_in_data", bus.cpu_in_data, 0);
        check("rst_counts", {bus.tx_count, bus.rx_count}, 0);
        check("rst_io_err", bus.io_err, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            bus.in_req = tbl[i].in_r; bus.out_req = tbl[i].out_r; bus.out_data = tbl[i].od;
            bus.tx_ready = tbl[i].trdy; bus.rx_valid = tbl[i].rv; bus.rx_data = tbl[i].rd;
            step();
            check($sformatf("row%0d_stall", i), s_stall, tbl[i].st);
            check($sformatf("row%0d_tx_valid", i), s_tv, tbl[i].tv);
            if (tbl[i].td >= 0) check($sformatf("row%0d_tx_data", i), s_td, tbl[i].td);
            check($sformatf("row%0d_rx_ready", i), s_rr, tbl[i].rr);
            if (tbl[i].cid >= 0) check($sformatf("row%0d_in_data", i), s_cid, tbl[i].cid);
            check($sformatf("row%0d_tx_count", i), s_tc, tbl[i].tc);
            check($sformatf("row%0d_rx_count", i), s_rc, tbl[i].rc);
        end
        idle_inputs();

        // IN on empty RX with a silent device: watchdog abort
        bus.in_req = 1;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!s_stall) break;
            stalls++;
        end
        check("wd_stall_cycles", stalls, LIMIT + 1);
        check("wd_abort_in_data", s_cid, 0);
        bus.in_req = 0;
        step();
        check("wd_io_err_set", s_err, 1);
        check("wd_rx_count", s_rc, 0);
        bus.err_clr = 1;
        step();
        bus.err_clr = 0;
        step();
        check("wd_io_err_clr", s_err, 0);

        // IN stalls, device supplies 0x7E on the third stall cycle
        bus.in_req = 1;
        step(); check("late_stall1", s_stall, 1);
        step(); check("late_stall2", s_stall, 1);
        bus.rx_valid = 1; bus.rx_data = 8'h7E;
        step(); check("late_stall3", s_stall, 1);
        bus.rx_valid = 0;
        step();
        check("late_release", s_stall, 0);
        check("late_data", s_cid, 8'h7E);
        bus.in_req = 0;
        step();
        check("late_io_err", s_err, 0);
        check("late_rx_count", s_rc, 0);

        // Asynchronous reset in the middle of a TX drain
        bus.rx_valid = 1; bus.rx_data = 8'h9A;
        step();
        bus.rx_valid = 0;
        for (int i = 0; i < 3; i++) begin
            bus.out_req = 1; bus.out_data = 8'(8'hC0 + i);
            step();
        end
        bus.out_req = 0; bus.tx_ready = 1;
        #2;
        check("pre_arst_tx_count", bus.tx_count, 3);
        rst = 0;
        #1;
        check("arst_tx_valid", bus.tx_valid, 0);
        check("arst_tx_count", bus.tx_count, 0);
        check("arst_rx_count", bus.rx_count, 0);
        check("arst_rx_ready", bus.rx_ready, 1);
        check("arst_tx_data", bus.tx_data, 0);
        txq.delete(); rxq.delete(); run = 0; err = 0;
        @(negedge clk); rst = 1; bus.tx_ready = 0;
        @(posedge clk); #1;
        step();

        // Randomized traffic: stalled requests are re-presented, device holds rx until accepted
        s_stall = 0;
        for (int i = 0; i < 3000; i++) begin
            int ph = (i / 150) % 3;
            if (!s_stall) begin
                int r = $urandom_range(0, 9);
                bus.in_req = r < 3;
                bus.out_req = r >= 3 && r < 6;
                bus.out_data = 8'($urandom);
            end
            bus.tx_ready = ph == 0 ? $urandom_range(0, 9) < 7 : ph == 1 ? $urandom_range(0, 9) < 2 : 1'b0;
            if (!(bus.rx_valid && !s_rr)) begin
                bus.rx_valid = ph == 2 ? 1'b0 : $urandom_range(0, 9) < 4;
                bus.rx_data = 8'($urandom);
            end
            bus.err_clr = $urandom_range(0, 19) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
